// File: rtl/shot_turn_controller_pkg.sv
// shot_turn_controller_pkg
// Shared definitions for the Battleship turn controller: fleet size and hit
// counter width, board cell codes, keyboard key kinds, the turn FSM state
// encoding and the number-key to column mapping.
package shot_turn_controller_pkg;

  localparam int FLEET_CELLS = 17;
  localparam int CNT_W       = 5;

  localparam logic [CNT_W-1:0] FLEET_CNT = CNT_W'(FLEET_CELLS);
  localparam logic [CNT_W-1:0] CNT_ONE   = 5'd1;

  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [1:0] KEY_LETTER  = 2'd0;
  localparam logic [1:0] KEY_NUMBER  = 2'd1;
  localparam logic [1:0] KEY_ENTER   = 2'd2;
  localparam logic [1:0] KEY_UNKNOWN = 2'd3;

  typedef enum logic [3:0] {
    GET_LETTER = 4'd0,
    GET_NUMBER = 4'd1,
    GET_ENTER  = 4'd2,
    RD_REQ     = 4'd3,
    RD_WAIT    = 4'd4,
    JUDGE      = 4'd5,
    WR_REQ     = 4'd6,
    DONE       = 4'd7,
    OVER       = 4'd8
  } state_t;

  // Number keys 1..9 select columns 0..8; the "10" key arrives as 0 and
  // selects column 9.
  function automatic logic [3:0] num_to_col(input logic [3:0] num);
    if (num == 4'd0) begin
      return 4'd9;
    end else begin
      return num - 4'd1;
    end
  endfunction

endpackage

// File: rtl/shot_key_collector.sv
// shot_key_collector
// Collects letter, number and Enter keys for one shot and emits a fire pulse
// together with the latched target row/column.
// Ports:
//   clock27, reset          clock and synchronous active-high reset
//   enable                  keys are accepted only while high
//   key_strobe/kind/value   decoded keyboard event
//   fire                    same-cycle pulse when Enter completes a target
//   row, col                latched target, valid with fire
module shot_key_collector
  import shot_turn_controller_pkg::*;
(
  input  logic       clock27,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_strobe,
  input  logic [1:0] key_kind,
  input  logic [3:0] key_value,
  output logic       fire,
  output logic [3:0] row,
  output logic [3:0] col
);

  state_t     st_r, st_nx_s;
  logic [3:0] row_r, row_nx_s;
  logic [3:0] col_r, col_nx_s;
  logic       fire_s;

  // Key-entry state machine; fire is combinational so the turn FSM can
  // raise its board request on the register edge right after Enter.
  always_comb begin
    st_nx_s  = st_r;
    row_nx_s = row_r;
    col_nx_s = col_r;
    fire_s   = 1'b0;
    if (enable && key_strobe) begin
      case (st_r)
        GET_LETTER: begin
          if (key_kind == KEY_LETTER) begin
            row_nx_s = key_value;
            st_nx_s  = GET_NUMBER;
          end else begin
            st_nx_s = st_r;
          end
        end
        GET_NUMBER: begin
          case (key_kind)
            KEY_LETTER: row_nx_s = key_value;
            KEY_NUMBER: begin
              col_nx_s = num_to_col(key_value);
              st_nx_s  = GET_ENTER;
            end
            KEY_ENTER, KEY_UNKNOWN: st_nx_s = st_r;
            default: st_nx_s = st_r;
          endcase
        end
        GET_ENTER: begin
          case (key_kind)
            KEY_LETTER: begin
              row_nx_s = key_value;
              st_nx_s  = GET_NUMBER;
            end
            KEY_NUMBER: col_nx_s = num_to_col(key_value);
            KEY_ENTER: begin
              fire_s  = 1'b1;
              st_nx_s = GET_LETTER;
            end
            default: st_nx_s = st_r;
          endcase
        end
        default: st_nx_s = GET_LETTER;
      endcase
    end else begin
      st_nx_s = st_r;
    end
  end

  // Key-entry state and target registers.
  always_ff @(posedge clock27) begin
    if (reset) begin
      st_r  <= GET_LETTER;
      row_r <= 4'd0;
      col_r <= 4'd0;
    end else begin
      st_r  <= st_nx_s;
      row_r <= row_nx_s;
      col_r <= col_nx_s;
    end
  end

  assign fire = fire_s;
  assign row  = row_r;
  assign col  = col_r;

endmodule

// File: rtl/shot_turn_controller.sv
// shot_turn_controller
// Sequences Battleship turns: takes a target from shot_key_collector, reads
// the opponent's cell through the shared board port (req/gnt), writes back
// hit/miss, keeps per-player hit totals, hands over the turn, flags game over.
// Ports:
//   clock27, reset                      clock, synchronous active-high reset
//   key_strobe, key_kind, key_value     decoded keyboard events
//   brd_req/gnt/we/addr/wdata/rdata     shared board-RAM port
//   turn                                player to move
//   shot_done, shot_hit, shot_reject    shot result pulses / held hit flag
//   game_over, winner                   sticky end-of-game flag and winner
// Build option: HIT_AGAIN_EN -- a hit keeps the turn with the attacker.
module shot_turn_controller
  import shot_turn_controller_pkg::*;
(
  input  logic       clock27,
  input  logic       reset,
  input  logic       key_strobe,
  input  logic [1:0] key_kind,
  input  logic [3:0] key_value,
  output logic       brd_req,
  input  logic       brd_gnt,
  output logic       brd_we,
  output logic [8:0] brd_addr,
  output logic [1:0] brd_wdata,
  input  logic [1:0] brd_rdata,
  output logic       turn,
  output logic       shot_done,
  output logic       shot_hit,
  output logic       shot_reject,
  output logic       game_over,
  output logic       winner
);

  state_t           state_r, state_nx_s;
  logic             turn_r, turn_nx_s;
  logic [CNT_W-1:0] cnt0_r, cnt0_nx_s, cnt1_r, cnt1_nx_s, att_cnt_s;
  logic [1:0]       cell_r, cell_nx_s;
  logic             hit_r, hit_nx_s;
  logic             req_r, req_nx_s, we_r, we_nx_s;
  logic [8:0]       addr_r, addr_nx_s;
  logic [1:0]       wdata_r, wdata_nx_s;
  logic             done_r, done_nx_s, shit_r, shit_nx_s, rej_r, rej_nx_s;
  logic             over_r, over_nx_s, winner_r, winner_nx_s;
  logic             fire_s;
  logic [3:0]       row_s, col_s;

  shot_key_collector u_keys (
    .clock27    (clock27),
    .reset      (reset),
    .enable     (state_r == GET_LETTER),
    .key_strobe (key_strobe),
    .key_kind   (key_kind),
    .key_value  (key_value),
    .fire       (fire_s),
    .row        (row_s),
    .col        (col_s)
  );

  assign att_cnt_s = turn_r ? cnt1_r : cnt0_r;

  // Board-port FSM; computes next state and next registered outputs. The
  // collector's GET_* phase is represented here by GET_LETTER.
  always_comb begin
    state_nx_s  = state_r;
    turn_nx_s   = turn_r;
    cnt0_nx_s   = cnt0_r;
    cnt1_nx_s   = cnt1_r;
    cell_nx_s   = cell_r;
    hit_nx_s    = hit_r;
    addr_nx_s   = addr_r;
    wdata_nx_s  = wdata_r;
    shit_nx_s   = shit_r;
    over_nx_s   = over_r;
    winner_nx_s = winner_r;
    done_nx_s   = 1'b0;
    rej_nx_s    = 1'b0;
    case (state_r)
      GET_LETTER: begin
        if (fire_s) begin
          addr_nx_s  = {~turn_r, row_s, col_s};
          state_nx_s = RD_REQ;
        end else begin
          state_nx_s = state_r;
        end
      end
      RD_REQ: begin
        if (brd_gnt) begin
          state_nx_s = RD_WAIT;
        end else begin
          state_nx_s = state_r;
        end
      end
      RD_WAIT: begin
        cell_nx_s  = brd_rdata;
        state_nx_s = JUDGE;
      end
      JUDGE: begin
        case (cell_r)
          CELL_SHIP: begin
            hit_nx_s   = 1'b1;
            wdata_nx_s = CELL_HIT;
            if (!turn_r && (cnt0_r != FLEET_CNT)) begin
              cnt0_nx_s = cnt0_r + CNT_ONE;
            end else if (turn_r && (cnt1_r != FLEET_CNT)) begin
              cnt1_nx_s = cnt1_r + CNT_ONE;
            end else begin
              cnt0_nx_s = cnt0_r;
            end
            state_nx_s = WR_REQ;
          end
          CELL_WATER: begin
            hit_nx_s   = 1'b0;
            wdata_nx_s = CELL_MISS;
            state_nx_s = WR_REQ;
          end
          default: begin
            rej_nx_s   = 1'b1;
            state_nx_s = GET_LETTER;
          end
        endcase
      end
      WR_REQ: begin
        if (brd_gnt) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      DONE: begin
        done_nx_s = 1'b1;
        shit_nx_s = hit_r;
        if (att_cnt_s == FLEET_CNT) begin
          over_nx_s   = 1'b1;
          winner_nx_s = turn_r;
          state_nx_s  = OVER;
        end else begin
`ifdef HIT_AGAIN_EN
          if (hit_r) begin
            turn_nx_s = turn_r;
          end else begin
            turn_nx_s = ~turn_r;
          end
`else
          turn_nx_s = ~turn_r;
`endif
          state_nx_s = GET_LETTER;
        end
      end
      OVER: state_nx_s = OVER;
      default: state_nx_s = GET_LETTER;
    endcase
    // Request follows the next state so it drops the cycle after gnt.
    req_nx_s = (state_nx_s == RD_REQ) || (state_nx_s == WR_REQ);
    we_nx_s  = (state_nx_s == WR_REQ);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock27) begin
    if (reset) begin
      state_r  <= GET_LETTER;
      turn_r   <= 1'b0;
      cnt0_r   <= '0;
      cnt1_r   <= '0;
      cell_r   <= 2'b00;
      hit_r    <= 1'b0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= 9'd0;
      wdata_r  <= 2'b00;
      done_r   <= 1'b0;
      shit_r   <= 1'b0;
      rej_r    <= 1'b0;
      over_r   <= 1'b0;
      winner_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      turn_r   <= turn_nx_s;
      cnt0_r   <= cnt0_nx_s;
      cnt1_r   <= cnt1_nx_s;
      cell_r   <= cell_nx_s;
      hit_r    <= hit_nx_s;
      req_r    <= req_nx_s;
      we_r     <= we_nx_s;
      addr_r   <= addr_nx_s;
      wdata_r  <= wdata_nx_s;
      done_r   <= done_nx_s;
      shit_r   <= shit_nx_s;
      rej_r    <= rej_nx_s;
      over_r   <= over_nx_s;
      winner_r <= winner_nx_s;
    end
  end

  assign brd_req     = req_r;
  assign brd_we      = we_r;
  assign brd_addr    = addr_r;
  assign brd_wdata   = wdata_r;
  assign turn        = turn_r;
  assign shot_done   = done_r;
  assign shot_hit    = shit_r;
  assign shot_reject = rej_r;
  assign game_over   = over_r;
  assign winner      = winner_r;

endmodule

// File: tb/tb_shot_turn_controller.sv
// tb_shot_turn_controller
// Directed bench for shot_turn_controller with a behavioural board RAM.
// Player 1's fleet: (2,4), row 0 cols 0..9, row 5 cols 0..5 (17 cells).
// Player 0's board is all water.
module tb_shot_turn_controller;

  logic       clock27 = 1'b0;
  logic       reset;
  logic       key_strobe;
  logic [1:0] key_kind;
  logic [3:0] key_value;
  logic       brd_req, brd_gnt, brd_we;
  logic [8:0] brd_addr;
  logic [1:0] brd_wdata;
  logic [1:0] brd_rdata;
  logic       turn, shot_done, shot_hit, shot_reject, game_over, winner;

  logic       gnt_en;
  logic       gnt_rd_only;

  int n_tests = 0;
  int n_fail  = 0;

  // board model state
  bit         written_r [512];
  bit   [1:0] wval_r    [512];
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  logic [8:0] last_waddr = 9'd0;
  logic [1:0] last_wdata = 2'b00;

  always #5 clock27 = ~clock27;

  assign brd_gnt = gnt_en | (gnt_rd_only & ~brd_we);

  shot_turn_controller dut (
    .clock27     (clock27),
    .reset       (reset),
    .key_strobe  (key_strobe),
    .key_kind    (key_kind),
    .key_value   (key_value),
    .brd_req     (brd_req),
    .brd_gnt     (brd_gnt),
    .brd_we      (brd_we),
    .brd_addr    (brd_addr),
    .brd_wdata   (brd_wdata),
    .brd_rdata   (brd_rdata),
    .turn        (turn),
    .shot_done   (shot_done),
    .shot_hit    (shot_hit),
    .shot_reject (shot_reject),
    .game_over   (game_over),
    .winner      (winner)
  );

  function automatic logic [1:0] init_cell(input logic [8:0] a);
    logic [3:0] r, c;
    r = a[7:4];
    c = a[3:0];
    if (!a[8]) return 2'b00;
    if (r == 4'd2 && c == 4'd4) return 2'b01;
    if (r == 4'd0 && c <= 4'd9) return 2'b01;
    if (r == 4'd5 && c <= 4'd5) return 2'b01;
    return 2'b00;
  endfunction

  // Board RAM model: one-cycle read latency, writes complete on grant.
  always @(posedge clock27) begin
    if (brd_req && brd_gnt) begin
      if (brd_we) begin
        written_r[brd_addr] <= 1'b1;
        wval_r[brd_addr]    <= brd_wdata;
        wr_cnt              <= wr_cnt + 1;
        last_waddr          <= brd_addr;
        last_wdata          <= brd_wdata;
      end else begin
        brd_rdata <= written_r[brd_addr] ? wval_r[brd_addr] : init_cell(brd_addr);
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_key(input logic [1:0] kind, input logic [3:0] value);
    key_strobe = 1'b1;
    key_kind   = kind;
    key_value  = value;
    @(negedge clock27);
    key_strobe = 1'b0;
  endtask

  // row 0..9, col 0..9; ends one negedge after Enter was sampled
  task automatic fire_shot(input int row, input int col);
    send_key(2'd0, 4'(row));
    send_key(2'd1, (col == 9) ? 4'd0 : 4'(col + 1));
    send_key(2'd2, 4'd0);
  endtask

  task automatic wait_result(input string tag, output int cyc, output logic rej);
    cyc = 0;
    while (!shot_done && !shot_reject && cyc < 200) begin
      @(negedge clock27);
      cyc++;
    end
    check_eq({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
    rej = shot_reject;
  endtask

  initial begin
    int   cyc, bad, rd0, wr0;
    logic rej;
    reset = 1'b1; key_strobe = 1'b0; key_kind = 2'd0; key_value = 4'd0;
    gnt_en = 1'b1; gnt_rd_only = 1'b0;
    repeat (3) @(negedge clock27);
    reset = 1'b0;

    // reset values
    check_eq("rst_turn", 32'(turn), 32'd0);
    check_eq("rst_req", 32'(brd_req), 32'd0);
    check_eq("rst_we", 32'(brd_we), 32'd0);
    check_eq("rst_addr", 32'(brd_addr), 32'd0);
    check_eq("rst_wdata", 32'(brd_wdata), 32'd0);
    check_eq("rst_done", 32'(shot_done), 32'd0);
    check_eq("rst_hit", 32'(shot_hit), 32'd0);
    check_eq("rst_over", 32'(game_over), 32'd0);
    check_eq("rst_winner", 32'(winner), 32'd0);

    // P0 fires C5 at a ship cell of player 1
    fire_shot(2, 4);
    check_eq("t1_req_lat", 32'(brd_req), 32'd1);
    check_eq("t1_raddr", 32'(brd_addr), 32'h124);
    check_eq("t1_we", 32'(brd_we), 32'd0);
    wait_result("t1", cyc, rej);
    check_eq("t1_latency", 32'(cyc), 32'd5);
    check_eq("t1_done", 32'(shot_done), 32'd1);
    check_eq("t1_hit", 32'(shot_hit), 32'd1);
    check_eq("t1_waddr", 32'(last_waddr), 32'h124);
    check_eq("t1_wdata", 32'(last_wdata), 32'd3);
    check_eq("t1_turn", 32'(turn), 32'd1);
    @(negedge clock27);
    check_eq("t1_done_pulse", 32'(shot_done), 32'd0);
    check_eq("t1_hit_held", 32'(shot_hit), 32'd1);

    // P1 fires J10 at water on player 0's board
    fire_shot(9, 9);
    wait_result("t2", cyc, rej);
    check_eq("t2_hit", 32'(shot_hit), 32'd0);
    check_eq("t2_waddr", 32'(last_waddr), 32'h099);
    check_eq("t2_wdata", 32'(last_wdata), 32'd2);
    check_eq("t2_turn", 32'(turn), 32'd0);

    // P0 repeats C5 -> rejected
    wr0 = wr_cnt;
    fire_shot(2, 4);
    wait_result("t3", cyc, rej);
    check_eq("t3_reject", 32'(rej), 32'd1);
    check_eq("t3_done", 32'(shot_done), 32'd0);
    repeat (3) @(negedge clock27);
    check_eq("t3_nowrite", 32'(wr_cnt), 32'(wr0));
    check_eq("t3_turn", 32'(turn), 32'd0);
    check_eq("t3_rej_pulse", 32'(shot_reject), 32'd0);

    // P0 fires A1 with grant withheld for 20 cycles
    gnt_en = 1'b0;
    rd0 = rd_cnt;
    fire_shot(0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(brd_req && !brd_we && brd_addr == 9'h100)) bad++;
      @(negedge clock27);
    end
    check_eq("t4_stall_stable", 32'(bad), 32'd0);
    check_eq("t4_no_read", 32'(rd_cnt), 32'(rd0));
    gnt_en = 1'b1;
    wait_result("t4", cyc, rej);
    check_eq("t4_hit", 32'(shot_hit), 32'd1);
    check_eq("t4_waddr", 32'(last_waddr), 32'h100);
    check_eq("t4_reads", 32'(rd_cnt), 32'(rd0 + 1));
    check_eq("t4_turn", 32'(turn), 32'd1);

    // P1: A, B, 3, Enter targets row 1 col 2; keys while busy are dropped
    send_key(2'd0, 4'd0);
    send_key(2'd0, 4'd1);
    send_key(2'd1, 4'd3);
    send_key(2'd2, 4'd0);
    check_eq("t5_raddr", 32'(brd_addr), 32'h012);
    send_key(2'd0, 4'd5);
    send_key(2'd1, 4'd7);
    send_key(2'd2, 4'd0);
    wait_result("t5", cyc, rej);
    check_eq("t5_waddr", 32'(last_waddr), 32'h012);
    check_eq("t5_wdata", 32'(last_wdata), 32'd2);
    check_eq("t5_turn", 32'(turn), 32'd0);
    rd0 = rd_cnt;
    repeat (10) @(negedge clock27);
    check_eq("t5_dropped", 32'(rd_cnt), 32'(rd0));

    // P0 sinks the remaining 15 cells; P1 misses in between
    for (int k = 0; k < 15; k++) begin
      if (k < 9) fire_shot(0, k + 1);
      else       fire_shot(5, k - 9);
      wait_result("t6_p0", cyc, rej);
      check_eq("t6_p0_hit", 32'(shot_hit), 32'd1);
      if (k < 14) begin
        check_eq("t6_not_over", 32'(game_over), 32'd0);
        check_eq("t6_turn1", 32'(turn), 32'd1);
        fire_shot(3 + k / 10, k % 10);
        wait_result("t6_p1", cyc, rej);
        check_eq("t6_p1_hit", 32'(shot_hit), 32'd0);
        check_eq("t6_turn0", 32'(turn), 32'd0);
      end else begin
        check_eq("t6_over", 32'(game_over), 32'd1);
        check_eq("t6_winner", 32'(winner), 32'd0);
      end
    end
    rd0 = rd_cnt;
    fire_shot(4, 8);
    repeat (10) @(negedge clock27);
    check_eq("t6_keys_ignored", 32'(rd_cnt), 32'(rd0));
    check_eq("t6_req_idle", 32'(brd_req), 32'd0);
    check_eq("t6_over_sticky", 32'(game_over), 32'd1);
    check_eq("t6_winner_held", 32'(winner), 32'd0);

    // reset in the middle of a pending write
    reset = 1'b1;
    @(negedge clock27);
    reset = 1'b0;
    gnt_en = 1'b0; gnt_rd_only = 1'b1;
    fire_shot(9, 9);
    cyc = 0;
    while (!(brd_req && brd_we) && cyc < 50) begin
      @(negedge clock27);
      cyc++;
    end
    check_eq("t7_write_pending", 32'(brd_req && brd_we), 32'd1);
    check_eq("t7_waddr", 32'(brd_addr), 32'h199);
    wr0 = wr_cnt;
    reset = 1'b1;
    @(negedge clock27);
    check_eq("t7_req", 32'(brd_req), 32'd0);
    check_eq("t7_we", 32'(brd_we), 32'd0);
    check_eq("t7_addr", 32'(brd_addr), 32'd0);
    check_eq("t7_wdata", 32'(brd_wdata), 32'd0);
    check_eq("t7_turn", 32'(turn), 32'd0);
    check_eq("t7_over", 32'(game_over), 32'd0);
    check_eq("t7_winner", 32'(winner), 32'd0);
    check_eq("t7_hit", 32'(shot_hit), 32'd0);
    reset = 1'b0;
    gnt_en = 1'b1; gnt_rd_only = 1'b0;
    repeat (5) @(negedge clock27);
    check_eq("t7_abandoned", 32'(wr_cnt), 32'(wr0));
    check_eq("t7_idle", 32'(brd_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
